// File: rtl/processor_scheduler.sv
// rtl/processor_scheduler.sv - screen-processor sequencer and shared-bus multiplexer
//
// Purpose:
//   Enables exactly one screen processor at a time and routes its memory,
//   graphic and interrupt signals to the shared controllers. On the active
//   processor's switch request it waits for any open interrupt to end, then
//   holds every enable low for GAP_CYCLES so the next processor restarts.
//   A fatal error from the active processor halts the system.
//
// Optional feature (macro SCHED_ERROR_RECOVERY_EN):
//   defined   - HALT lasts 16 cycles, then processor 0 is restarted via GAP.
//   undefined - HALT is terminal until RESET.
//
// Ports:
//   CLK, RESET           clock, synchronous active-high reset
//   P_ENABLE             one-hot processor enable
//   P_SWITCH_REQUEST     per-processor switch request
//   P_FATAL_ERROR        per-processor fatal error
//   P_MEM_ENABLE/WRITE   per-processor memory strobes
//   P_MEM_ADDR/DATA_W    per-processor 16-bit address / write data, packed
//   P_GPU_DRAW           per-processor draw strobe
//   P_INT_IACK/IEND      per-processor interrupt acknowledge / end
//   MEM_*, GPU_DRAW      shared memory / graphic controller outputs
//   INT_IACK, INT_IEND   shared interrupt controller outputs
//   ACTIVE_ID            current or most recent processor
//   HALTED               high while halted

module processor_scheduler #(
  parameter int NUM_PROC      = 3,
  parameter int GAP_CYCLES    = 2,
  parameter int DRAIN_TIMEOUT = 255
) (
  input  logic                  CLK,
  input  logic                  RESET,
  output logic [NUM_PROC-1:0]   P_ENABLE,
  input  logic [NUM_PROC-1:0]   P_SWITCH_REQUEST,
  input  logic [NUM_PROC-1:0]   P_FATAL_ERROR,
  input  logic [NUM_PROC-1:0]   P_MEM_ENABLE,
  input  logic [NUM_PROC-1:0]   P_MEM_WRITE,
  input  logic [16*NUM_PROC-1:0] P_MEM_ADDR,
  input  logic [16*NUM_PROC-1:0] P_MEM_DATA_W,
  input  logic [NUM_PROC-1:0]   P_GPU_DRAW,
  input  logic [NUM_PROC-1:0]   P_INT_IACK,
  input  logic [NUM_PROC-1:0]   P_INT_IEND,
  output logic                  MEM_ENABLE,
  output logic                  MEM_WRITE,
  output logic [15:0]           MEM_ADDR,
  output logic [15:0]           MEM_DATA_W,
  output logic                  GPU_DRAW,
  output logic                  INT_IACK,
  output logic                  INT_IEND,
  output logic [1:0]            ACTIVE_ID,
  output logic                  HALTED
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    GAP   = 3'd3,
    HALT  = 3'd4
  } state_t;

  state_t          state;
  logic [1:0]      active;
  logic            irq_open;
  logic [GW-1:0]   gap_cnt;
  logic [7:0]      drain_cnt;

  logic            live;
  logic            fatal_act;
  logic            switch_act;
  logic            iack_m;
  logic            iend_m;
  logic            iend_force;
  logic            irq_next;
  logic [1:0]      active_inc;

  // Reset gates the outputs directly so they read 0 even before the first edge.
  assign live       = ((state == RUN) || (state == DRAIN)) && !RESET;
  assign fatal_act  = P_FATAL_ERROR[active];
  assign switch_act = P_SWITCH_REQUEST[active];
  assign iack_m     = live && P_INT_IACK[active];
  assign iend_m     = live && P_INT_IEND[active];
  // Acknowledge and end in the same cycle leave the interrupt closed.
  assign irq_next   = (irq_open || iack_m) && !iend_m;
  assign active_inc = (active == 2'(NUM_PROC - 1)) ? 2'd0 : active + 2'd1;

  // Timeout cycle: interrupt still open, nothing ended it this cycle and the
  // drain budget is spent, so the block closes it on the processor's behalf.
  assign iend_force = !RESET && (state == DRAIN) && !fatal_act && irq_open &&
                      !iend_m && (drain_cnt == 8'(DRAIN_TIMEOUT));

  always_comb begin
    P_ENABLE = '0;
    if (live) P_ENABLE[active] = 1'b1;
  end

  assign MEM_ENABLE = live && P_MEM_ENABLE[active];
  assign MEM_WRITE  = live && P_MEM_WRITE[active];
  assign MEM_ADDR   = live ? P_MEM_ADDR[{active, 4'b0000} +: 16]   : 16'h0000;
  assign MEM_DATA_W = live ? P_MEM_DATA_W[{active, 4'b0000} +: 16] : 16'h0000;
  assign GPU_DRAW   = live && P_GPU_DRAW[active];
  assign INT_IACK   = iack_m;
  assign INT_IEND   = iend_m || iend_force;
  assign ACTIVE_ID  = RESET ? 2'd0 : active;
  assign HALTED     = (state == HALT) && !RESET;

`ifdef SCHED_ERROR_RECOVERY_EN
  logic [3:0] halt_cnt;

  // Counts cycles spent in HALT; idle at 0 everywhere else.
  always_ff @(posedge CLK) begin
    if (RESET || (state != HALT)) halt_cnt <= 4'd0;
    else                          halt_cnt <= halt_cnt + 4'd1;
  end
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= BOOT;
      active    <= 2'd0;
      irq_open  <= 1'b0;
      gap_cnt   <= '0;
      drain_cnt <= 8'd0;
    end else begin
      case (state)
        BOOT: begin
          state  <= RUN;
          active <= 2'd0;
        end
        RUN: begin
          irq_open <= irq_next;
          if (fatal_act) begin
            state <= HALT;
          end else if (switch_act) begin
            state     <= DRAIN;
            drain_cnt <= 8'd0;
          end
        end
        DRAIN: begin
          irq_open <= irq_next;
          if (fatal_act) begin
            state <= HALT;
          end else if (!irq_open || iend_m || iend_force) begin
            // An end seen this cycle lets GAP start on the very next edge.
            state    <= GAP;
            gap_cnt  <= '0;
            irq_open <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt + 8'd1;
          end
        end
        GAP: begin
          if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
            state  <= RUN;
            active <= active_inc;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        HALT: begin
`ifdef SCHED_ERROR_RECOVERY_EN
          if (halt_cnt == 4'd15) begin
            // Park on the last ID so the GAP exit increment wraps to 0.
            state    <= GAP;
            gap_cnt  <= '0;
            irq_open <= 1'b0;
            active   <= 2'(NUM_PROC - 1);
          end
`endif
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_processor_scheduler.sv
// tb/tb_processor_scheduler.sv - self-checking bench for processor_scheduler

module tb_processor_scheduler;

  localparam int N = 3;
  localparam int G = 2;
  localparam int T = 4;

  logic           CLK = 1'b0;
  logic           RESET;
  logic [N-1:0]   sw, fat, men, mwr, gd, ia, ie;
  logic [16*N-1:0] ma, md;
  logic [N-1:0]   en;
  logic           mem_en, mem_wr, gpu, iack, iend, halted;
  logic [15:0]    mem_addr, mem_data;
  logic [1:0]     active_id;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: 0 boot, 1 run, 2 drain, 3 gap, 4 halt
  int m_state = 0;
  int m_active = 0;
  int m_gap_left = 0;
  int m_drain_n = 0;
  int m_halt_n = 0;
  bit m_irq = 0;

  processor_scheduler #(.NUM_PROC(N), .GAP_CYCLES(G), .DRAIN_TIMEOUT(T)) dut (
    .CLK(CLK), .RESET(RESET),
    .P_ENABLE(en), .P_SWITCH_REQUEST(sw), .P_FATAL_ERROR(fat),
    .P_MEM_ENABLE(men), .P_MEM_WRITE(mwr), .P_MEM_ADDR(ma), .P_MEM_DATA_W(md),
    .P_GPU_DRAW(gd), .P_INT_IACK(ia), .P_INT_IEND(ie),
    .MEM_ENABLE(mem_en), .MEM_WRITE(mem_wr), .MEM_ADDR(mem_addr), .MEM_DATA_W(mem_data),
    .GPU_DRAW(gpu), .INT_IACK(iack), .INT_IEND(iend),
    .ACTIVE_ID(active_id), .HALTED(halted)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    sw = '0; fat = '0; men = '0; mwr = '0; gd = '0; ia = '0; ie = '0;
    ma = '0; md = '0;
  endtask

  // Compare every output against the model for the current cycle, advance the
  // model by one clock, and return at the next falling edge.
  task automatic step_cycle();
    int a;
    bit live, fire, ended;
    logic [N-1:0] en_e;
    #1;
    a = m_active;
    live  = !RESET && (m_state == 1 || m_state == 2);
    ended = live && ie[a];
    fire  = !RESET && m_state == 2 && !fat[a] && m_irq && !ended && m_drain_n == T;
    en_e = '0;
    if (live) en_e[a] = 1'b1;
    check("p_enable",  32'(en),        32'(en_e));
    check("active_id", 32'(active_id), RESET ? 32'd0 : 32'(m_active));
    check("halted",    32'(halted),    32'(!RESET && m_state == 4));
    check("mem_en",    32'(mem_en),    32'(live && men[a]));
    check("mem_wr",    32'(mem_wr),    32'(live && mwr[a]));
    check("mem_addr",  32'(mem_addr),  live ? 32'(ma[16*a +: 16]) : 32'd0);
    check("mem_data",  32'(mem_data),  live ? 32'(md[16*a +: 16]) : 32'd0);
    check("gpu_draw",  32'(gpu),       32'(live && gd[a]));
    check("int_iack",  32'(iack),      32'(live && ia[a]));
    check("int_iend",  32'(iend),      32'(ended || fire));

    if (RESET) begin
      m_state = 0; m_active = 0; m_irq = 0; m_gap_left = 0; m_drain_n = 0;
    end else begin
      case (m_state)
        0: begin m_state = 1; m_active = 0; end
        1: begin
          m_irq = (m_irq || ia[a]) && !ie[a];
          if (fat[a]) begin m_state = 4; m_halt_n = 0; end
          else if (sw[a]) begin m_state = 2; m_drain_n = 0; end
        end
        2: begin
          if (fat[a]) begin
            m_state = 4; m_halt_n = 0;
          end else if (!m_irq || ended || m_drain_n == T) begin
            m_state = 3; m_gap_left = G; m_irq = 0;
          end else begin
            m_drain_n++;
            m_irq = 1;
          end
        end
        3: begin
          m_gap_left--;
          if (m_gap_left == 0) begin
            m_state = 1;
            m_active = (m_active + 1) % N;
          end
        end
        default: begin
`ifdef SCHED_ERROR_RECOVERY_EN
          m_halt_n++;
          if (m_halt_n == 16) begin
            m_state = 3; m_gap_left = G; m_irq = 0; m_active = N - 1;
          end
`endif
        end
      endcase
    end
    @(negedge CLK);
  endtask

  initial begin
    clear_inputs();
    RESET = 1'b1;
    @(negedge CLK);

    // Reset and boot
    step_cycle(); step_cycle();
    check("rst_enable", 32'(en), 32'd0);
    check("rst_active", 32'(active_id), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    RESET = 1'b0;
    ma[15:0] = 16'h0800;
    step_cycle();
    check("boot_enable", 32'(en), 32'b001);
    check("boot_addr", 32'(mem_addr), 32'h0800);

    // Clean switch 0 -> 1
    sw[0] = 1'b1; step_cycle(); sw = '0;
    check("sw_drain_en", 32'(en), 32'b001);
    step_cycle(); check("sw_gap1", 32'(en), 32'd0);
    step_cycle(); check("sw_gap2", 32'(en), 32'd0);
    step_cycle(); check("sw_new_en", 32'(en), 32'b010);
    check("sw_new_id", 32'(active_id), 32'd1);

    // Drain on proc 1: open interrupt holds DRAIN until IEND
    ia[1] = 1'b1; step_cycle(); ia = '0;
    sw[1] = 1'b1; step_cycle(); sw = '0;
    check("drain_en0", 32'(en), 32'b010);
    for (int i = 0; i < 3; i++) begin
      step_cycle(); check("drain_hold", 32'(en), 32'b010);
    end
    ie[1] = 1'b1; #1;
    check("drain_iend", 32'(iend), 32'd1);
    step_cycle(); ie = '0;
    check("drain_gap", 32'(en), 32'd0);
    step_cycle(); step_cycle();
    check("drain_next_en", 32'(en), 32'b100);

    // Timeout on proc 2: IEND forced 4 cycles after DRAIN entry
    ia[2] = 1'b1; step_cycle(); ia = '0;
    sw[2] = 1'b1; step_cycle(); sw = '0;
    check("to_iend_d0", 32'(iend), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      step_cycle();
      check("to_iend", 32'(iend), (i == 4) ? 32'd1 : 32'd0);
    end
    check("to_en_last", 32'(en), 32'b100);
    step_cycle();
    check("to_gap_en", 32'(en), 32'd0);
    check("to_gap_iend", 32'(iend), 32'd0);
    step_cycle(); step_cycle();
    check("wrap_en", 32'(en), 32'b001);
    check("wrap_id", 32'(active_id), 32'd0);

    // Isolation: inactive processors cannot switch or halt
    sw = 3'b110; fat = 3'b110;
    for (int i = 0; i < 3; i++) begin
      step_cycle();
      check("iso_en", 32'(en), 32'b001);
      check("iso_halt", 32'(halted), 32'd0);
    end
    clear_inputs();

    // Fatal beats same-cycle switch on proc 1
    sw[0] = 1'b1; step_cycle(); sw = '0;
    step_cycle(); step_cycle(); step_cycle();
    check("fat_pre_en", 32'(en), 32'b010);
    fat[1] = 1'b1; sw[1] = 1'b1; step_cycle(); clear_inputs();
    check("fat_halted", 32'(halted), 32'd1);
    check("fat_en", 32'(en), 32'd0);
    check("fat_id", 32'(active_id), 32'd1);
`ifdef SCHED_ERROR_RECOVERY_EN
    repeat (15) step_cycle();
    check("rec_still_halted", 32'(halted), 32'd1);
    step_cycle();
    check("rec_gap_halted", 32'(halted), 32'd0);
    check("rec_gap_en", 32'(en), 32'd0);
    step_cycle(); step_cycle();
    check("rec_en", 32'(en), 32'b001);
    check("rec_id", 32'(active_id), 32'd0);
`else
    repeat (20) step_cycle();
    check("halt_sticky", 32'(halted), 32'd1);
    check("halt_en", 32'(en), 32'd0);
    check("halt_id", 32'(active_id), 32'd1);
`endif

    // Randomized traffic against the model
    RESET = 1'b1; step_cycle(); RESET = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      RESET = ($urandom_range(249) == 0);
      for (int i = 0; i < N; i++) begin
        sw[i]  = ($urandom_range(11) == 0);
        fat[i] = ($urandom_range(399) == 0);
        men[i] = $urandom_range(1);
        mwr[i] = $urandom_range(1);
        gd[i]  = $urandom_range(1);
        ia[i]  = ($urandom_range(7) == 0);
        ie[i]  = ($urandom_range(9) == 0);
      end
      ma = {16'($urandom), 16'($urandom), 16'($urandom)};
      md = {16'($urandom), 16'($urandom), 16'($urandom)};
      step_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
